gpio_input_filter_bank: RTL and testbench
=========================================

Name: gpio_input_filter_bank

Overview:
Multi-channel GPIO input conditioning block. It is the parametrised successor of the single-channel synchronizer/edge-detect stage. Per channel it provides a configurable-depth synchronizer, an optional debounce/glitch filter, rise/fall edge pulses, and sticky per-channel interrupt pending bits with rise, fall, high and low trigger modes. It sits between the pad inputs and the GPIO register file / interrupt controller, and uses no clock gates.

Parameters:
NrChannels, 32, number of independent GPIO input channels (>=1)
NrSyncStages, 2, synchronizer flops per channel (>=2)
CntWidth, 8, width of the debounce counter and threshold

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset, asynchronous, active-high
en_i  input  NrChannels  per-channel sampling enable
serial_i  input  NrChannels  raw asynchronous pad inputs
deb_en_i  input  NrChannels  per-channel debounce enable
deb_thresh_i  input  CntWidth  shared debounce threshold T
irq_rise_en_i  input  NrChannels  interrupt on rising edge
irq_fall_en_i  input  NrChannels  interrupt on falling edge
irq_high_en_i  input  NrChannels  interrupt while level high
irq_low_en_i  input  NrChannels  interrupt while level low
irq_clr_i  input  NrChannels  one-cycle clear of pending bit
serial_o  output  NrChannels  filtered, synchronized level
r_edge_o  output  NrChannels  one-cycle rising-edge pulse
f_edge_o  output  NrChannels  one-cycle falling-edge pulse
irq_pending_o  output  NrChannels  sticky pending bits
irq_o  output  1  OR of irq_pending_o

Behaviour:
- One clock, clk_i. Reset is asynchronous and active-high on rst_i. All state is cleared by rst_i: sync chains, filt, filt_q, counters and pending bits go to 0. Reset values: serial_o=0, r_edge_o=0, f_edge_o=0, irq_pending_o=0, irq_o=0.
- Per-channel sync: NrSyncStages flops. The output of the last flop is s.
- Per-channel debounce, with effective threshold Te = deb_en_i ? deb_thresh_i : 0:
  - If s == filt: cnt <= 0.
  - Else if cnt >= Te: filt <= s and cnt <= 0.
  - Else: cnt <= cnt + 1.
  - Net effect: filt follows s only after Te+1 consecutive mismatching cycles. Any shorter pulse is rejected.
  - cnt never wraps, because the >= compare catches a threshold lowered mid-count on the next cycle.
- serial_o = filt.
- Latency from a serial_i change to serial_o: NrSyncStages+1 cycles when debounce is off, NrSyncStages+1+T when debounce is on.
- Edge detect: filt_q <= filt every enabled cycle.
  - r_edge_o = filt & ~filt_q & ~blank.
  - f_edge_o = ~filt & filt_q & ~blank.
  - Pulses are combinational, exactly 1 cycle wide, and coincide with the first cycle of the new serial_o value.
- Disable (en_i[n]=0):
  - The channel's sync chain, cnt, filt and filt_q hold their values.
  - Edges are forced to 0 and no pending bit is set.
  - irq_clr_i is still honoured.
- Re-enable: a per-channel blanking counter is loaded with NrSyncStages+1 on the cycle en_i rises.
  - blank = (counter != 0). The counter decrements while enabled.
  - Edge pulses and all interrupt sets are suppressed while blank is high. This prevents stale-sample spurious edges.
  - serial_o keeps tracking the input during blanking.
- Pending set condition for channel n:
  - (irq_rise_en & r_edge) | (irq_fall_en & f_edge) | (irq_high_en & filt & ~blank & en) | (irq_low_en & ~filt & ~blank & en).
- Pending update: pending <= set | (pending & ~irq_clr).
  - Set wins over a simultaneous clear.
  - A level interrupt re-asserts on the cycle after a clear while the level persists.
- irq_o = |irq_pending_o, combinational from the registered bits.
- Enabling several irq modes at once is legal. Their set conditions are ORed.
- Reset asserted mid-operation clears everything immediately. After release, the first edge can appear no earlier than NrSyncStages+1 cycles.

Test Plan:
1. Reset and idle: assert rst_i with serial_i=all 1s, then release with en_i=all 1s and debounce off. All outputs are 0 during reset. serial_o goes to all 1s 3 cycles after release (NrSyncStages=2). r_edge_o pulses once on all channels in that same cycle.
2. Debounce: ch0 with deb_en=1, T=4. A 4-cycle high glitch gives serial_o[0] staying 0 and no edge. A 5-cycle high pulse gives serial_o[0]=1 at cycle 3+4 after the input rose, with r_edge_o[0] pulsing once.
3. Edge interrupts: ch3 with irq_rise_en=1 and a toggling input. irq_pending_o[3] sets with r_edge_o[3] (registered, visible the next cycle), is unaffected by the falling edge, and irq_clr_i[3] clears it. A clear in the same cycle as a set leaves pending=1.
4. Level interrupt: ch5 with irq_high_en=1, input held high. Pending stays 1 despite repeated clears. After the input goes low, one clear brings it to 0 and it stays 0.
5. Disable/re-enable: toggle ch7's input while en_i[7]=0, leaving it high. Then re-enable. serial_o[7] updates, but no r_edge_o[7] and no pending bit appear for 3 cycles. After that, edges work normally.
6. Threshold lowered mid-count: T=10, mismatch held for 6 cycles, then T changed to 3. serial_o updates on the next cycle with no cnt wrap.

Source files
------------

// File: rtl/gpio_input_filter_bank.sv
// Multi-channel GPIO input conditioning: synchronizer, debounce filter,
// edge pulses and sticky interrupt pending bits per channel.
module gpio_input_filter_bank #(
  parameter int unsigned NrChannels   = 32,
  parameter int unsigned NrSyncStages = 2,
  parameter int unsigned CntWidth     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NrChannels-1:0] en_i,
  input  logic [NrChannels-1:0] serial_i,
  input  logic [NrChannels-1:0] deb_en_i,
  input  logic [CntWidth-1:0]   deb_thresh_i,
  input  logic [NrChannels-1:0] irq_rise_en_i,
  input  logic [NrChannels-1:0] irq_fall_en_i,
  input  logic [NrChannels-1:0] irq_high_en_i,
  input  logic [NrChannels-1:0] irq_low_en_i,
  input  logic [NrChannels-1:0] irq_clr_i,
  output logic [NrChannels-1:0] serial_o,
  output logic [NrChannels-1:0] r_edge_o,
  output logic [NrChannels-1:0] f_edge_o,
  output logic [NrChannels-1:0] irq_pending_o,
  output logic                  irq_o
);

  localparam int unsigned       BlankW    = $clog2(NrSyncStages + 2);
  localparam logic [BlankW-1:0] BlankLoad = BlankW'(NrSyncStages + 1);

  logic [NrChannels-1:0] filt;
  logic [NrChannels-1:0] filt_q;
  logic [NrChannels-1:0] blank;
  logic [NrChannels-1:0] irq_set;
  logic [NrChannels-1:0] irq_pending_q;

  for (genvar g = 0; g < NrChannels; g++) begin : gen_ch
    logic [NrSyncStages-1:0] sync_q;
    logic [CntWidth-1:0]     cnt_q;
    logic [CntWidth-1:0]     thresh;
    logic                    s;
    logic                    filt_r;
    logic                    filt_d1;
    logic                    en_q;
    logic                    en_rise;
    logic [BlankW-1:0]       blank_q;

    assign s       = sync_q[NrSyncStages-1];
    assign thresh  = deb_en_i[g] ? deb_thresh_i : '0;
    assign en_rise = en_i[g] & ~en_q;

    // The >= compare lets a threshold lowered mid-count take effect at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync_q  <= '0;
        cnt_q   <= '0;
        filt_r  <= 1'b0;
        filt_d1 <= 1'b0;
      end else if (en_i[g]) begin
        sync_q  <= {sync_q[NrSyncStages-2:0], serial_i[g]};
        filt_d1 <= filt_r;
        if (s == filt_r) begin
          cnt_q <= '0;
        end else if (cnt_q >= thresh) begin
          filt_r <= s;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + CntWidth'(1);
        end
      end
    end

    // en_q resets high so leaving reset with the channel enabled is not a re-enable.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        en_q    <= 1'b1;
        blank_q <= '0;
      end else begin
        en_q <= en_i[g];
        if (en_rise) begin
          blank_q <= BlankLoad;
        end else if (en_i[g] && (blank_q != '0)) begin
          blank_q <= blank_q - BlankW'(1);
        end
      end
    end

    assign filt[g]   = filt_r;
    assign filt_q[g] = filt_d1;
    assign blank[g]  = en_rise | (blank_q != '0);
  end

  assign serial_o = filt;
  assign r_edge_o = en_i & filt & ~filt_q & ~blank;
  assign f_edge_o = en_i & ~filt & filt_q & ~blank;

  assign irq_set = (irq_rise_en_i & r_edge_o)
                 | (irq_fall_en_i & f_edge_o)
                 | (irq_high_en_i & filt & ~blank & en_i)
                 | (irq_low_en_i & ~filt & ~blank & en_i);

  // Set wins over a simultaneous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_pending_q <= '0;
    end else begin
      irq_pending_q <= irq_set | (irq_pending_q & ~irq_clr_i);
    end
  end

  assign irq_pending_o = irq_pending_q;
  assign irq_o         = |irq_pending_q;

endmodule

// File: tb/tb_gpio_input_filter_bank.sv
// Scoreboard bench for gpio_input_filter_bank: stimulus queues cycle-tagged
// expectations, a negedge monitor pops and compares them.
module tb_gpio_input_filter_bank;

  localparam int N = 32;
  localparam int W = 8;

  localparam int F_SER  = 0;
  localparam int F_RISE = 1;
  localparam int F_FALL = 2;
  localparam int F_PEND = 3;
  localparam int F_IRQ  = 4;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [N-1:0] en_i, serial_i, deb_en_i;
  logic [W-1:0] deb_thresh_i;
  logic [N-1:0] irq_rise_en_i, irq_fall_en_i, irq_high_en_i, irq_low_en_i, irq_clr_i;
  logic [N-1:0] serial_o, r_edge_o, f_edge_o, irq_pending_o;
  logic         irq_o;

  gpio_input_filter_bank #(.NrChannels(N), .NrSyncStages(2), .CntWidth(W)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .serial_i(serial_i),
    .deb_en_i(deb_en_i), .deb_thresh_i(deb_thresh_i),
    .irq_rise_en_i(irq_rise_en_i), .irq_fall_en_i(irq_fall_en_i),
    .irq_high_en_i(irq_high_en_i), .irq_low_en_i(irq_low_en_i),
    .irq_clr_i(irq_clr_i), .serial_o(serial_o), .r_edge_o(r_edge_o),
    .f_edge_o(f_edge_o), .irq_pending_o(irq_pending_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          fld;
    logic [31:0] mask;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic exp_bit(int d, int fld, int ch, logic v, string nm);
    exp_t e;
    e.cyc  = cyc + d;
    e.fld  = fld;
    e.mask = 32'd1 << ch;
    e.val  = 32'(v) << ch;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic exp_vec(int d, int fld, logic [31:0] v, string nm);
    exp_t e;
    e.cyc  = cyc + d;
    e.fld  = fld;
    e.mask = '1;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic compare(exp_t e);
    logic [31:0] act;
    case (e.fld)
      F_SER:   act = serial_o;
      F_RISE:  act = r_edge_o;
      F_FALL:  act = f_edge_o;
      F_PEND:  act = irq_pending_o;
      default: act = {31'b0, irq_o};
    endcase
    if (e.fld == F_IRQ) e.mask = 32'd1;
    total++;
    if ((act & e.mask) !== e.val) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h mask=%h", e.name, cyc, act & e.mask, e.val, e.mask);
    end
  endtask

  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        compare(sb[i]);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL %s stale expectation for cyc=%0d now=%0d", sb[i].name, sb[i].cyc, cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    en_i = '1;
    serial_i = '1;
    deb_en_i = '0;
    deb_thresh_i = '0;
    irq_rise_en_i = '0;
    irq_fall_en_i = '0;
    irq_high_en_i = '0;
    irq_low_en_i = '0;
    irq_clr_i = '0;

    // reset and idle
    step(2);
    exp_vec(0, F_SER, 32'h0, "rst_serial");
    exp_vec(0, F_RISE, 32'h0, "rst_rise");
    exp_vec(0, F_FALL, 32'h0, "rst_fall");
    exp_vec(0, F_PEND, 32'h0, "rst_pend");
    exp_vec(0, F_IRQ, 32'h0, "rst_irq");
    rst_i = 1'b0;
    exp_vec(2, F_SER, 32'h0, "rel_serial_early");
    exp_vec(3, F_SER, 32'hffff_ffff, "rel_serial");
    exp_vec(2, F_RISE, 32'h0, "rel_rise_early");
    exp_vec(3, F_RISE, 32'hffff_ffff, "rel_rise");
    exp_vec(4, F_RISE, 32'h0, "rel_rise_once");
    exp_vec(4, F_IRQ, 32'h0, "rel_irq");
    step(5);
    serial_i = '0;
    exp_vec(3, F_FALL, 32'hffff_ffff, "idle_fall");
    step(8);

    // debounce on ch0, T=4
    deb_en_i[0] = 1'b1;
    deb_thresh_i = 8'd4;
    step(1);
    serial_i[0] = 1'b1;
    for (int d = 3; d <= 9; d++) exp_bit(d, F_SER, 0, 1'b0, "deb_glitch_serial");
    exp_bit(3, F_RISE, 0, 1'b0, "deb_glitch_rise3");
    exp_bit(7, F_RISE, 0, 1'b0, "deb_glitch_rise7");
    step(4);
    serial_i[0] = 1'b0;
    step(10);
    serial_i[0] = 1'b1;
    exp_bit(6, F_SER, 0, 1'b0, "deb_pulse_early");
    exp_bit(7, F_SER, 0, 1'b1, "deb_pulse_serial");
    exp_bit(6, F_RISE, 0, 1'b0, "deb_pulse_rise_early");
    exp_bit(7, F_RISE, 0, 1'b1, "deb_pulse_rise");
    exp_bit(8, F_RISE, 0, 1'b0, "deb_pulse_rise_once");
    exp_bit(11, F_SER, 0, 1'b1, "deb_fall_early");
    exp_bit(12, F_SER, 0, 1'b0, "deb_fall_serial");
    exp_bit(12, F_FALL, 0, 1'b1, "deb_fall_edge");
    step(5);
    serial_i[0] = 1'b0;
    step(12);

    // rising-edge interrupt on ch3
    irq_rise_en_i[3] = 1'b1;
    step(1);
    serial_i[3] = 1'b1;
    exp_bit(3, F_RISE, 3, 1'b1, "rise_edge");
    exp_bit(3, F_PEND, 3, 1'b0, "rise_pend_reg");
    exp_bit(4, F_PEND, 3, 1'b1, "rise_pend");
    exp_bit(4, F_IRQ, 0, 1'b1, "rise_irq");
    step(6);
    serial_i[3] = 1'b0;
    exp_bit(3, F_FALL, 3, 1'b1, "rise_fall_edge");
    for (int d = 3; d <= 5; d++) exp_bit(d, F_PEND, 3, 1'b1, "rise_pend_on_fall");
    step(6);
    irq_clr_i[3] = 1'b1;
    exp_bit(0, F_PEND, 3, 1'b1, "rise_pend_before_clr");
    exp_bit(1, F_PEND, 3, 1'b0, "rise_clr");
    step(1);
    irq_clr_i[3] = 1'b0;
    exp_bit(0, F_IRQ, 0, 1'b0, "rise_irq_clr");
    exp_bit(2, F_PEND, 3, 1'b0, "rise_clr_stays");
    step(2);
    serial_i[3] = 1'b1;
    exp_bit(3, F_RISE, 3, 1'b1, "setclr_edge");
    step(3);
    irq_clr_i[3] = 1'b1;
    exp_bit(1, F_PEND, 3, 1'b1, "set_wins_clr");
    step(1);
    irq_clr_i[3] = 1'b0;
    step(1);
    irq_clr_i[3] = 1'b1;
    exp_bit(0, F_PEND, 3, 1'b1, "setclr_sticky");
    exp_bit(1, F_PEND, 3, 1'b0, "setclr_cleared");
    step(1);
    irq_clr_i[3] = 1'b0;
    step(3);

    // high-level interrupt on ch5
    irq_high_en_i[5] = 1'b1;
    step(1);
    serial_i[5] = 1'b1;
    exp_bit(3, F_PEND, 5, 1'b0, "lvl_pend_reg");
    exp_bit(4, F_PEND, 5, 1'b1, "lvl_pend");
    step(6);
    irq_clr_i[5] = 1'b1;
    for (int d = 1; d <= 3; d++) exp_bit(d, F_PEND, 5, 1'b1, "lvl_pend_vs_clr");
    exp_bit(2, F_IRQ, 0, 1'b1, "lvl_irq");
    step(3);
    irq_clr_i[5] = 1'b0;
    step(1);
    serial_i[5] = 1'b0;
    exp_bit(3, F_SER, 5, 1'b0, "lvl_serial_low");
    exp_bit(3, F_PEND, 5, 1'b1, "lvl_pend_last");
    exp_bit(4, F_PEND, 5, 1'b1, "lvl_pend_sticky");
    step(4);
    irq_clr_i[5] = 1'b1;
    exp_bit(1, F_PEND, 5, 1'b0, "lvl_clr");
    step(1);
    irq_clr_i[5] = 1'b0;
    exp_bit(2, F_PEND, 5, 1'b0, "lvl_clr_stays");
    exp_bit(2, F_IRQ, 0, 1'b0, "lvl_irq_clr");
    step(3);

    // disable / re-enable on ch7
    irq_rise_en_i[7] = 1'b1;
    en_i[7] = 1'b0;
    step(1);
    serial_i[7] = 1'b1;
    for (int d = 0; d <= 8; d++) begin
      exp_bit(d, F_SER, 7, 1'b0, "dis_serial_hold");
      exp_bit(d, F_RISE, 7, 1'b0, "dis_rise");
      exp_bit(d, F_PEND, 7, 1'b0, "dis_pend");
    end
    step(2);
    serial_i[7] = 1'b0;
    step(2);
    serial_i[7] = 1'b1;
    step(5);
    en_i[7] = 1'b1;
    exp_bit(2, F_SER, 7, 1'b0, "reen_serial_early");
    exp_bit(3, F_SER, 7, 1'b1, "reen_serial");
    for (int d = 0; d <= 6; d++) exp_bit(d, F_RISE, 7, 1'b0, "reen_blank_rise");
    for (int d = 0; d <= 7; d++) exp_bit(d, F_PEND, 7, 1'b0, "reen_blank_pend");
    step(6);
    serial_i[7] = 1'b0;
    exp_bit(3, F_FALL, 7, 1'b1, "reen_fall");
    step(4);
    serial_i[7] = 1'b1;
    exp_bit(3, F_RISE, 7, 1'b1, "reen_rise");
    exp_bit(3, F_PEND, 7, 1'b0, "reen_pend_reg");
    exp_bit(4, F_PEND, 7, 1'b1, "reen_pend");
    step(5);
    en_i[7] = 1'b0;
    irq_clr_i[7] = 1'b1;
    exp_bit(1, F_PEND, 7, 1'b0, "dis_clr");
    step(1);
    irq_clr_i[7] = 1'b0;
    en_i[7] = 1'b1;
    step(6);

    // threshold lowered mid-count on ch9
    deb_en_i[9] = 1'b1;
    deb_thresh_i = 8'd10;
    step(1);
    serial_i[9] = 1'b1;
    exp_bit(8, F_SER, 9, 1'b0, "thr_serial_early");
    exp_bit(9, F_SER, 9, 1'b1, "thr_serial");
    exp_bit(9, F_RISE, 9, 1'b1, "thr_rise");
    exp_bit(10, F_RISE, 9, 1'b0, "thr_rise_once");
    step(8);
    deb_thresh_i = 8'd3;
    step(6);

    step(4);
    while (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s never checked (cyc=%0d)", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
